// File: rtl/vuvxu_b8_lane_rblen_seq_if.sv
// rtl/vuvxu_b8_lane_rblen_seq_if.sv - issue handshake bundle for the lane rblen sequencer
interface vuvxu_b8_lane_rblen_seq_if #(
    parameter int NPORT   = 8,
    parameter int SZ_VLEN = 8
);
    logic               issue_val;
    logic               issue_rdy;
    logic [NPORT-1:0]   issue_mask;
    logic [2:0]         issue_bank;
    logic [3:0]         issue_bcnt;
    logic [SZ_VLEN-1:0] issue_vlen;

    modport master (
        output issue_val, issue_mask, issue_bank, issue_bcnt, issue_vlen,
        input  issue_rdy
    );

    modport slave (
        input  issue_val, issue_mask, issue_bank, issue_bcnt, issue_vlen,
        output issue_rdy
    );
endinterface

// File: rtl/vuvxu_b8_lane_rblen_seq.sv
// rtl/vuvxu_b8_lane_rblen_seq.sv - per-lane bank sequencer driving crossbar read-port enables
module vuvxu_b8_lane_rblen_seq #(
    parameter int NBANK   = 8,
    parameter int NPORT   = 8,
    parameter int SZ_VLEN = 8
) (
    input  logic                         clk,
    input  logic                         reset_n,
    vuvxu_b8_lane_rblen_seq_if.slave     issue,
    input  logic                         stall,
    output logic [NPORT-1:0]             rblen [0:NBANK-1],
    output logic                         busy,
    output logic                         done
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state, state_nxt;
    logic [SZ_VLEN-1:0] cnt, cnt_nxt;
    logic [2:0]         cur, cur_nxt;
    logic [3:0]         bcnt, bcnt_nxt;
    logic [NPORT-1:0]   mask, mask_nxt;
    logic               nop_done, nop_done_nxt;
    logic [NPORT-1:0]   rblen_nxt [0:NBANK-1];
    logic               last, fire, en_nxt, hold;
    logic [3:0]         eff_bcnt;
    logic [3:0]         cur_inc;

    // The last element is consumed this cycle, so a new op may load without a bubble
    assign last            = (state == RUN) && (cnt == SZ_VLEN'(1)) && !stall;
    assign issue.issue_rdy = (state == IDLE) || last;
    assign fire            = issue.issue_val && issue.issue_rdy;
    assign busy            = (state == RUN);
    assign done            = last || nop_done;

    // Next-state: load on fire, hold on stall, otherwise step to the next bank or retire
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        cur_nxt      = cur;
        bcnt_nxt     = bcnt;
        mask_nxt     = mask;
        nop_done_nxt = 1'b0;
        en_nxt       = 1'b0;
        hold         = 1'b0;
        eff_bcnt     = (issue.issue_bcnt == 4'd0 || issue.issue_bcnt > 4'd8) ? 4'd8 : issue.issue_bcnt;
        cur_inc      = {1'b0, cur} + 4'd1;
        if (fire) begin
            if (issue.issue_vlen != '0) begin
                state_nxt = RUN;
                cnt_nxt   = issue.issue_vlen;
                cur_nxt   = ({1'b0, issue.issue_bank} < eff_bcnt) ? issue.issue_bank : 3'd0;
                bcnt_nxt  = eff_bcnt;
                mask_nxt  = issue.issue_mask;
                en_nxt    = 1'b1;
            end else begin
                state_nxt    = IDLE;
                cnt_nxt      = '0;
                cur_nxt      = 3'd0;
                nop_done_nxt = 1'b1;
            end
        end else if (state == RUN) begin
            if (stall) begin
                hold = 1'b1;
            end else if (cnt > SZ_VLEN'(1)) begin
                cnt_nxt = cnt - SZ_VLEN'(1);
                // Wrap at the op's active bank count rather than the physical bank count
                cur_nxt = (cur_inc >= bcnt) ? 3'd0 : cur_inc[2:0];
                en_nxt  = 1'b1;
            end else begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
                cur_nxt   = 3'd0;
            end
        end
        for (int b = 0; b < NBANK; b++) begin
            if (hold) begin
                rblen_nxt[b] = rblen[b];
            end else begin
                rblen_nxt[b] = (en_nxt && (3'(b) == cur_nxt)) ? mask_nxt : '0;
            end
        end
    end

    // State register; reset wins over any fire in the same cycle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cur      <= 3'd0;
            bcnt     <= 4'd8;
            mask     <= '0;
            nop_done <= 1'b0;
            for (int b = 0; b < NBANK; b++) begin
                rblen[b] <= '0;
            end
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            cur      <= cur_nxt;
            bcnt     <= bcnt_nxt;
            mask     <= mask_nxt;
            nop_done <= nop_done_nxt;
            for (int b = 0; b < NBANK; b++) begin
                rblen[b] <= rblen_nxt[b];
            end
        end
    end

endmodule

// File: tb/tb_vuvxu_b8_lane_rblen_seq.sv
// tb/tb_vuvxu_b8_lane_rblen_seq.sv - scoreboard bench for the lane rblen sequencer
module tb_vuvxu_b8_lane_rblen_seq;

    typedef struct {
        int         bank;
        logic [7:0] mask;
        bit         busy;
        bit         done;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       stall = 1'b0;
    logic [7:0] rblen [0:7];
    logic       busy;
    logic       done;
    bit         mon_en = 1'b0;
    int         tests = 0;
    int         fails = 0;
    exp_t       q [$];

    vuvxu_b8_lane_rblen_seq_if #(.NPORT(8), .SZ_VLEN(8)) ifc ();

    vuvxu_b8_lane_rblen_seq #(.NBANK(8), .NPORT(8), .SZ_VLEN(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .issue   (ifc),
        .stall   (stall),
        .rblen   (rblen),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [63:0] flat_rblen();
        logic [63:0] f;
        for (int b = 0; b < 8; b++) f[b*8 +: 8] = rblen[b];
        return f;
    endfunction

    function automatic logic [63:0] flat_exp(input int bank, input logic [7:0] m);
        logic [63:0] f;
        f = '0;
        if (bank >= 0) f[bank*8 +: 8] = m;
        return f;
    endfunction

    task automatic pe(input int bank, input logic [7:0] m, input bit bz, input bit dn);
        exp_t e;
        e.bank = bank; e.mask = m; e.busy = bz; e.done = dn;
        q.push_back(e);
    endtask

    // Monitor: every cycle with busy or done consumes one expected record; idle cycles must be quiet
    always @(negedge clk) begin
        if (mon_en) begin
            if (busy === 1'b1 || done === 1'b1) begin
                tests++;
                if (q.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_output: busy=%b done=%b rblen=%h, required no activity", busy, done, flat_rblen());
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    if (busy !== e.busy || done !== e.done || flat_rblen() !== flat_exp(e.bank, e.mask)) begin
                        fails++;
                        $display("FAIL seq_step: busy=%b done=%b rblen=%h, required busy=%b done=%b rblen=%h",
                                 busy, done, flat_rblen(), e.busy, e.done, flat_exp(e.bank, e.mask));
                    end
                end
            end else begin
                tests++;
                if (flat_rblen() !== 64'h0 || busy !== 1'b0 || done !== 1'b0) begin
                    fails++;
                    $display("FAIL idle_quiet: busy=%b done=%b rblen=%h, required all zero", busy, done, flat_rblen());
                end
            end
        end
    end

    task automatic issue_op(input logic [7:0] m, input logic [2:0] b, input logic [3:0] c, input logic [7:0] v);
        bit fired;
        int n;
        ifc.issue_val  = 1'b1;
        ifc.issue_mask = m;
        ifc.issue_bank = b;
        ifc.issue_bcnt = c;
        ifc.issue_vlen = v;
        fired = 1'b0;
        n = 0;
        while (!fired && n < 50) begin
            fired = (ifc.issue_rdy === 1'b1);
            @(posedge clk); #1;
            n++;
        end
        ifc.issue_val = 1'b0;
        if (!fired) begin
            tests++; fails++;
            $display("FAIL issue_timeout: issue_rdy=%b, required 1 within 50 cycles", ifc.issue_rdy);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(posedge clk); #1;
        while (busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy === 1'b1) begin
            tests++; fails++;
            $display("FAIL idle_timeout: busy=%b, required 0 within 100 cycles", busy);
        end
    endtask

    initial begin
        ifc.issue_val  = 1'b0;
        ifc.issue_mask = '0;
        ifc.issue_bank = '0;
        ifc.issue_bcnt = '0;
        ifc.issue_vlen = '0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;

        tests++;
        if (ifc.issue_rdy !== 1'b1 || busy !== 1'b0 || done !== 1'b0 || flat_rblen() !== 64'h0) begin
            fails++;
            $display("FAIL reset_state: rdy=%b busy=%b done=%b rblen=%h, required rdy=1 busy=0 done=0 rblen=0",
                     ifc.issue_rdy, busy, done, flat_rblen());
        end
        mon_en = 1'b1;

        // Basic walk: banks 2..5
        pe(2, 8'h12, 1, 0); pe(3, 8'h12, 1, 0); pe(4, 8'h12, 1, 0); pe(5, 8'h12, 1, 1);
        issue_op(8'h12, 3'd2, 4'd8, 8'd4);
        wait_idle();

        // bcnt=3 with out-of-range start bank: starts at 0 and wraps at 3
        pe(0, 8'h3c, 1, 0); pe(1, 8'h3c, 1, 0); pe(2, 8'h3c, 1, 0); pe(0, 8'h3c, 1, 0); pe(1, 8'h3c, 1, 1);
        issue_op(8'h3c, 3'd5, 4'd3, 8'd5);
        wait_idle();

        // Stall for three cycles on the second element
        pe(1, 8'ha5, 1, 0);
        pe(2, 8'ha5, 1, 0); pe(2, 8'ha5, 1, 0); pe(2, 8'ha5, 1, 0); pe(2, 8'ha5, 1, 0);
        pe(3, 8'ha5, 1, 0); pe(4, 8'ha5, 1, 0); pe(5, 8'ha5, 1, 0); pe(6, 8'ha5, 1, 1);
        issue_op(8'ha5, 3'd1, 4'd8, 8'd6);
        @(posedge clk); #1 stall = 1'b1;
        repeat (3) @(posedge clk);
        #1 stall = 1'b0;
        wait_idle();

        // Back-to-back: second op held pending until the first op's final cycle
        pe(0, 8'h01, 1, 0); pe(1, 8'h01, 1, 1);
        issue_op(8'h01, 3'd0, 4'd8, 8'd2);
        pe(6, 8'h80, 1, 0); pe(0, 8'h80, 1, 0); pe(1, 8'h80, 1, 1);
        issue_op(8'h80, 3'd6, 4'd7, 8'd3);
        wait_idle();

        // No-op retirement, then an all-zero mask sequence
        pe(-1, 8'h00, 0, 1);
        issue_op(8'h77, 3'd3, 4'd8, 8'd0);
        wait_idle();
        pe(-1, 8'h00, 1, 0); pe(-1, 8'h00, 1, 0); pe(-1, 8'h00, 1, 1);
        issue_op(8'h00, 3'd4, 4'd8, 8'd3);
        wait_idle();

        // bcnt above 8 behaves as 8
        pe(7, 8'h0f, 1, 0); pe(0, 8'h0f, 1, 1);
        issue_op(8'h0f, 3'd7, 4'd12, 8'd2);
        wait_idle();

        // Reset mid-run at cnt==3: aborted without done
        pe(4, 8'hff, 1, 0); pe(5, 8'hff, 1, 0); pe(6, 8'hff, 1, 0); pe(7, 8'hff, 1, 0);
        issue_op(8'hff, 3'd4, 4'd8, 8'd6);
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        @(posedge clk); #1;

        // Fresh op after abort, bcnt=0 meaning 8
        pe(7, 8'h05, 1, 0); pe(0, 8'h05, 1, 1);
        issue_op(8'h05, 3'd7, 4'd0, 8'd2);
        wait_idle();
        repeat (3) @(posedge clk);
        #1;

        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d records left, required 0", q.size());
        end
        mon_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/vuvxu_b8_lane_rblen_seq.md
VUVXU_B8_LANE_RBLEN_SEQ -- requirements
Module: vuvxu_b8_lane_rblen_seq

Interface
REQ-001: Parameter NBANK, default 8, number of register-file banks per lane.
REQ-002: Parameter NPORT, default 8, read-port count (width of each rblen entry, the crossbar port-enable vector).
REQ-003: Parameter SZ_VLEN, default 8, element-count width.
REQ-004: clk  input  1  sole clock; all state updates on rising edge.
REQ-005: reset_n  input  1  reset, synchronous, active-low.
REQ-006: issue_val  input  1  issue request valid.
REQ-007: issue_rdy  output  1  sequencer can accept an op this cycle.
REQ-008: issue_mask  input  NPORT  crossbar read ports used by the op.
REQ-009: issue_bank  input  3  starting bank.
REQ-010: issue_bcnt  input  4  active bank count, 1..8; value 0 and values above 8 mean 8.
REQ-011: issue_vlen  input  SZ_VLEN  element count; 0 means no-op.
REQ-012: stall  input  1  downstream crossbar/FU stall; freezes sequencing.
REQ-013: rblen[0:NBANK-1]  output  NPORT each  registered per-bank port enables feeding the lane crossbar.
REQ-014: busy  output  1  op in progress (state RUN).
REQ-015: done  output  1  single-cycle pulse; final element consumed or no-op retired.

Function
REQ-016: FSM SHALL have two states: IDLE and RUN.
REQ-017: Handshake SHALL fire when issue_val and issue_rdy are both 1 on the same rising edge; inputs are sampled only on a fire.
REQ-018: issue_rdy SHALL be 1 in IDLE, and 1 in RUN only when cnt==1 and stall==0; otherwise 0.
REQ-019: On a fire with vlen>0: next cycle state=RUN, cnt=vlen, cur bank = issue_bank if issue_bank<bcnt else 0, rblen[cur]=issue_mask, all other rblen 0.
REQ-020: On a fire with vlen==0: state SHALL remain or become IDLE; rblen all 0 next cycle; done=1 for the next cycle only.
REQ-021: In RUN with stall==0 and cnt>1: cnt decrements by 1, cur advances to (cur+1) mod bcnt, rblen moves to the new bank; exactly one bank is enabled per cycle.
REQ-022: In RUN with stall==1: state, cnt, cur and all rblen SHALL hold; done=0.
REQ-023: done SHALL be combinationally 1 when state==RUN, cnt==1 and stall==0 (the last enable is being consumed), plus the vlen==0 retirement case of REQ-020.
REQ-024: In RUN with cnt==1 and stall==0, the next cycle SHALL go to IDLE with rblen all 0, unless a fire occurs in the same cycle, in which case the new op loads per REQ-019/020 (back-to-back, no bubble).
REQ-025: issue_mask==0 SHALL be legal: the sequence runs vlen cycles with all rblen 0 and done still pulses.
REQ-026: Bank wrap SHALL use bcnt, not NBANK: with bcnt=3 the order from bank 1 is 1,2,0,1,...
REQ-027: busy SHALL equal (state==RUN).
REQ-028: No more than one op SHALL be in flight; issue_val while issue_rdy==0 is ignored and has no side effect.

Reset
REQ-029: While reset_n==0 at a rising edge: state=IDLE, cnt=0, cur=0, all rblen=0, busy=0, done=0; issue_rdy SHALL read 1 from the first cycle after reset release.
REQ-030: Reset asserted in RUN SHALL abort the op with no done pulse; a fire in the reset cycle is discarded.

Verification
REQ-031: Reset, then issue mask=0x12, bank=2, bcnt=8, vlen=4 -> cycles t+1..t+4: rblen[2],[3],[4],[5]=0x12 in turn; done in cycle t+4; IDLE at t+5.
REQ-032: bcnt=3, bank=5, vlen=5 -> start bank 0; sequence 0,1,2,0,1; done on 5th cycle.
REQ-033: vlen=6 with stall held high in cycles t+2..t+4 -> rblen[bank+1] held 3 extra cycles; done at t+9; element order unchanged.
REQ-034: Second op presented in the last cycle of the first (cnt==1, stall=0) -> accepted, new bank enabled next cycle, no idle gap; done pulses once per op.
REQ-035: Issue with vlen=0 -> done=1 next cycle, rblen stays all 0, busy stays 0; issue mask=0, vlen=3 -> busy 3 cycles, rblen all 0, done on 3rd.
REQ-036: reset_n low mid-RUN (cnt=3) -> next cycle all rblen 0, busy 0, no done; a fresh op issued afterwards runs normally.
